// File: rtl/demux16_pkg.sv
// Shared constants and types for the 16-bit demux router.
package demux16_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned MAX_OUT = 16;

    typedef logic [DATA_W-1:0] word_t;

    function automatic logic sel_in_range(input int unsigned sel, input int unsigned n);
        return (sel < n) && (sel < MAX_OUT);
    endfunction

endpackage

// File: rtl/demux16_slot.sv
// One output channel's single-entry holding register with valid/ready drain.
module demux16_slot
    import demux16_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load,
    input  word_t data_in,
    input  logic  out_ready,
    output logic  out_valid,
    output word_t out_data,
    output logic  can_accept
);

    assign can_accept = !out_valid || out_ready;

    // A load on the same edge as a drain keeps the slot full with the new word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= data_in;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux16_router.sv
// Registered 1-to-NUM_OUT steering of 16-bit words with per-channel holding slots.
// Optional broadcast input enabled by defining DEMUX16_BROADCAST_EN.
module demux16_router
    import demux16_pkg::*;
#(
    parameter int NUM_OUT = 4,
    parameter int SEL_W   = $clog2(NUM_OUT)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DATA_W-1:0]           in_data,
    input  logic [SEL_W-1:0]            in_sel,
    input  logic                        in_valid,
`ifdef DEMUX16_BROADCAST_EN
    input  logic                        in_bcast,
`endif
    output logic                        in_ready,
    output logic [NUM_OUT*DATA_W-1:0]   out_data,
    output logic [NUM_OUT-1:0]          out_valid,
    input  logic [NUM_OUT-1:0]          out_ready,
    output logic                        drop_err
);

    logic [NUM_OUT-1:0] can_acc;
    logic [NUM_OUT-1:0] load;
    logic               sel_ok;
    logic               sel_ready;
    logic               bcast;
    logic               accept;

`ifdef DEMUX16_BROADCAST_EN
    assign bcast = in_bcast;
`else
    assign bcast = 1'b0;
`endif

    assign sel_ok = sel_in_range(32'(in_sel), NUM_OUT);

    always_comb begin
        sel_ready = 1'b0;
        for (int unsigned k = 0; k < NUM_OUT; k++) begin
            if (in_sel == SEL_W'(k)) sel_ready = can_acc[k];
        end
    end

    // Out-of-range selects are always accepted so the producer never stalls on them.
    always_comb begin
        if (bcast)       in_ready = &can_acc;
        else if (sel_ok) in_ready = sel_ready;
        else             in_ready = 1'b1;
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        load = '0;
        for (int unsigned k = 0; k < NUM_OUT; k++) begin
            load[k] = accept && (bcast || (sel_ok && in_sel == SEL_W'(k)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_err <= 1'b0;
        else        drop_err <= accept && !bcast && !sel_ok;
    end

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
        demux16_slot u_slot (
            .clk        (clk),
            .rst_n      (rst_n),
            .load       (load[k]),
            .data_in    (in_data),
            .out_ready  (out_ready[k]),
            .out_valid  (out_valid[k]),
            .out_data   (out_data[k*DATA_W +: DATA_W]),
            .can_accept (can_acc[k])
        );
    end

endmodule

// File: doc/demux16_router.md
# demux16_router

Registered 1-to-N steering block for 16-bit words; the inverse of the 16-bit 2:1 select path. Accepts one word per cycle on a valid/ready input with a destination select, and places it in a one-entry holding slot on the selected output channel, each with its own valid/ready handshake. It sits between a single producer (datapath result bus) and several independent consumers (register file write port, memory write buffer, I/O) so back-pressure on one consumer does not stall words bound for the others.

## Interface
- `NUM_OUT`, 4, number of output channels (2..16)
- `SEL_W`, `$clog2(NUM_OUT)`, select width (derived; do not override)
- `clk`  input  1  rising-edge clock
- `rst_n`  input  1  asynchronous, active-low reset
- `in_data`  input  16  word to steer
- `in_sel`  input  SEL_W  destination channel index
- `in_valid`  input  1  producer has a word
- `in_ready`  output  1  word accepted this cycle when `in_valid && in_ready`
- `out_data`  output  NUM_OUT×16  per-channel held word (packed, channel 0 in bits [15:0])
- `out_valid`  output  NUM_OUT  per-channel slot full
- `out_ready`  input  NUM_OUT  per-channel consumer accepts
- `drop_err`  output  1  one-cycle pulse: word accepted with `in_sel >= NUM_OUT` and discarded

## Operation
- One clock `clk`; reset asynchronous, active-low `rst_n`.
- Each channel k has one slot: `out_valid[k]`, `out_data[k]`.
- Channel k drains when `out_valid[k] && out_ready[k]`; slot clears next edge unless refilled same edge.
- `in_ready` (combinational) = selected slot empty OR selected slot draining this cycle. For `in_sel >= NUM_OUT`: `in_ready` = 1.
- Accept (`in_valid && in_ready`, valid sel): `out_data[sel]` <= `in_data`, `out_valid[sel]` <= 1.
- Simultaneous drain and refill on same channel: slot stays valid, data replaced with new word; no bubble.
- Accept with invalid sel: no slot changes; `drop_err` = 1 next cycle only.
- Unselected channels drain independently regardless of input activity.
- `out_data[k]` holds its last value after drain (not cleared); only `out_valid` is meaningful.
- No reordering issue: each channel holds at most one word; words to the same channel leave in acceptance order.
- `in_ready` must not depend on `in_valid`; depends only on `in_sel`, slot state, `out_ready`.

## Timing
- Reset (async assert, sync-safe deassert by upstream): `out_valid` = 0, `out_data` = 0, `drop_err` = 0; `in_ready` then = 1 for any sel.
- Latency: word accepted at edge n is visible on `out_valid`/`out_data` after edge n (usable cycle n+1).
- Throughput: 1 word/cycle to any channel whose consumer holds `out_ready` = 1.
- Reset asserted mid-operation: all held words discarded immediately (asynchronously), `drop_err` cleared.
- Consumer with `out_ready` held 0 blocks only inputs addressed to that channel.

## Configuration
- `DEMUX16_BROADCAST_EN` defined: adds input `in_bcast` (1 bit). When `in_bcast` = 1, `in_sel` ignored; `in_ready` = every slot empty-or-draining; accept loads `in_data` into all NUM_OUT slots in the same edge; `drop_err` never asserted for broadcast words.
- Not defined: no `in_bcast` port; behaviour exactly as in Operation.

## Structure
- Package `demux16_pkg`: `DATA_W` = 16 constant, `word_t` (logic [15:0]) typedef, max channel count constant (16).
- Sub-module `demux16_slot`: one channel's holding register (load, data_in, out_ready → out_valid, out_data, can_accept); instantiated NUM_OUT times via generate.
- Top handles select decode, `in_ready` mux, invalid-sel detection, broadcast gating.

## Test plan
- Reset then idle: after `rst_n` 0→1, all `out_valid` = 0, `out_data` = 0, `in_ready` = 1 for sel 0..3.
- Single steer: `in_data` = 16'h00FF, `in_sel` = 2, valid one cycle, all `out_ready` = 0 → next cycle `out_valid` = 4'b0100, channel 2 data = 16'h00FF; second word to sel 2 sees `in_ready` = 0 until `out_ready[2]` = 1.
- Back-to-back pass-through: `out_ready[1]` = 1, stream 16'h01FF, 16'h003F, 16'hFFFF to sel 1 on consecutive cycles → `in_ready` stays 1, channel 1 shows each word one cycle after acceptance, no bubbles.
- Independence: channel 0 full with `out_ready[0]` = 0; word 16'h1234 to sel 3 accepted same cycle → `out_valid[3]` = 1, channel 0 unchanged.
- Invalid select (NUM_OUT = 3): word 16'hBEEF with `in_sel` = 3 → `in_ready` = 1, no `out_valid` change, `drop_err` high exactly one cycle.
- Broadcast (`DEMUX16_BROADCAST_EN`): channel 1 full and stalled, `in_bcast` = 1, data 16'hA5A5 → `in_ready` = 0; release `out_ready[1]` → accepted, all four channels show 16'hA5A5 next cycle.
